// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions (used by uart_rx and uart_tx).
// Holds the receiver FSM state encoding and the frame-size constants.
// Optional macro UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

   localparam int OVERSAMPLE_DEFAULT = 16;
   localparam int DATA_BITS          = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_state_t;
`else
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_state_t;
`endif

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
// Ports: clock (system clock), reset_n (async active-low reset),
//        d (asynchronous input), q (synchronized output, resets to 1).
module sync_2ff (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver, 8 data bits, LSB first, 1 stop bit.
// Ports: clock, reset_n (async active-low), sample_tick (OVERSAMPLE x baud
//        enable), rx (serial line, idle high), byte_received/valid/ready
//        (output holding register with valid/ready handshake),
//        framing_error and overrun (one-clock pulses),
//        parity_error (one-clock pulse, only with UART_RX_PARITY_EN).
// Macro UART_RX_PARITY_EN: inserts an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       sample_tick,
   input  logic       rx,
   output logic [7:0] byte_received,
   output logic       valid,
   input  logic       ready,
   output logic       framing_error,
   output logic       overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_error
`endif
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic                 rx_s;
   uart_state_t          state;
   logic [CW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;

   sync_2ff u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (rx),
      .q       (rx_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         byte_received <= '0;
         valid         <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         // Consume first; a load later in this block overrides valid back to 1.
         if (valid && ready)
            valid <= 1'b0;

         if (sample_tick) begin
            case (state)
               IDLE: begin
                  tick_cnt <= '0;
                  if (!rx_s)
                     state <= START;
               end
               START: begin
                  if (tick_cnt == HALF_M1) begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt <= '0;
                     shift    <= {rx_s, shift[DATA_BITS-1:1]};
                     if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt     <= '0;
                     parity_error <= (^shift) ^ rx_s;
                     state        <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (tick_cnt == FULL_M1) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        state <= IDLE;
                        // Holding register full and not drained now: keep old byte.
                        if (valid && !ready) begin
                           overrun <= 1'b1;
                        end else begin
                           byte_received <= shift;
                           valid         <= 1'b1;
                        end
                     end else begin
                        framing_error <= 1'b1;
                        state         <= WAIT_HIGH;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               WAIT_HIGH: begin
                  tick_cnt <= '0;
                  if (rx_s)
                     state <= IDLE;
               end
               default: begin
                  state    <= IDLE;
                  tick_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
   import uart_pkg::*;

   localparam int OVS = 16;

   logic       clock       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       sample_tick = 1'b0;
   logic       rx          = 1'b1;
   logic       ready       = 1'b0;
   logic [7:0] byte_received;
   logic       valid;
   logic       framing_error;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   int total = 0;
   int bad   = 0;

   uart_rx #(.OVERSAMPLE(OVS)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .sample_tick   (sample_tick),
      .rx            (rx),
      .byte_received (byte_received),
      .valid         (valid),
      .ready         (ready),
      .framing_error (framing_error),
      .overrun       (overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_error  (parity_error)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) sample_tick <= ~sample_tick;

   // Event monitor, sampled on the falling edge.
   logic [7:0] got_q[$];
   int fe_cnt = 0, ov_cnt = 0, vcyc = 0, pe_cnt = 0;
   always @(negedge clock) begin
      if (reset_n) begin
         if (valid && ready) got_q.push_back(byte_received);
         if (valid) vcyc++;
         if (framing_error) fe_cnt++;
         if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_error) pe_cnt++;
`endif
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         do @(negedge clock); while (!sample_tick);
      end
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_ticks(OVS);
   endtask

   task automatic send_frame_raw(input logic [7:0] d, input logic par, input logic stopb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`endif
      send_bit(stopb);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb);
      send_frame_raw(d, ^d, stopb);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stopb;
      int         exp_acc;
      logic [7:0] exp_byte;
      int         exp_fe;
   } vec_t;

   vec_t vt[5];
   int qb, feb, ovb, vb, peb;

   task automatic snap();
      qb = got_q.size(); feb = fe_cnt; ovb = ov_cnt; vb = vcyc; peb = pe_cnt;
   endtask

   initial begin
      vt[0] = '{8'h58, 1'b1, 1, 8'h58, 0};
      vt[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
      vt[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      vt[3] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      vt[4] = '{8'h33, 1'b0, 0, 8'h00, 1};

      repeat (3) @(negedge clock);
      check("reset_byte", int'(byte_received), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_fe", int'(framing_error), 0);
      check("reset_ov", int'(overrun), 0);
      reset_n = 1'b1;
      wait_ticks(2 * OVS);

      // Table-driven single frames with ready held high.
      ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         snap();
         send_frame(vt[v].data, vt[v].stopb);
         rx = 1'b1;
         wait_ticks(2 * OVS);
         check($sformatf("vec%0d_acc", v), got_q.size() - qb, vt[v].exp_acc);
         check($sformatf("vec%0d_vcyc", v), vcyc - vb, vt[v].exp_acc);
         check($sformatf("vec%0d_fe", v), fe_cnt - feb, vt[v].exp_fe);
         check($sformatf("vec%0d_ov", v), ov_cnt - ovb, 0);
         if (got_q.size() > qb)
            check($sformatf("vec%0d_byte", v), int'(got_q[qb]), int'(vt[v].exp_byte));
      end

      // Back-to-back frames with consumer stalled: overrun keeps the first byte.
      ready = 1'b0;
      snap();
      send_frame(8'hAC, 1'b1);
      send_frame(8'h58, 1'b1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("ovr_byte", int'(byte_received), 8'hAC);
      check("ovr_valid", int'(valid), 1);
      check("ovr_pulses", ov_cnt - ovb, 1);
      check("ovr_acc_stalled", got_q.size() - qb, 0);
      ready = 1'b1;
      repeat (4) @(negedge clock);
      check("ovr_acc", got_q.size() - qb, 1);
      if (got_q.size() > qb) check("ovr_acc_byte", int'(got_q[qb]), 8'hAC);
      check("ovr_valid_clr", int'(valid), 0);

      // Short low glitch from idle.
      snap();
      rx = 1'b0;
      wait_ticks(OVS / 4);
      rx = 1'b1;
      wait_ticks(3 * OVS);
      check("glitch_acc", got_q.size() - qb, 0);
      check("glitch_fe", fe_cnt - feb, 0);
      check("glitch_state", int'(dut.state), int'(IDLE));

      // Bad stop bit followed by a long break, then recovery.
      snap();
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      wait_ticks(30 * OVS);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("brk_fe", fe_cnt - feb, 1);
      check("brk_acc", got_q.size() - qb, 0);
      send_frame(8'h0F, 1'b1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("brk_rec_acc", got_q.size() - qb, 1);
      if (got_q.size() > qb) check("brk_rec_byte", int'(got_q[qb]), 8'h0F);
      check("brk_fe_after", fe_cnt - feb, 1);

      // Reset asserted in the middle of data bit 4 of 0xFF.
      snap();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b1;
      wait_ticks(OVS / 2);
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_mid_valid", int'(valid), 0);
      check("rst_mid_byte", int'(byte_received), 0);
      reset_n = 1'b1;
      wait_ticks(OVS / 2 + 4 * OVS);
      send_frame(8'h3C, 1'b1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("rst_acc", got_q.size() - qb, 1);
      if (got_q.size() > qb) check("rst_byte", int'(got_q[qb]), 8'h3C);
      check("rst_fe", fe_cnt - feb, 0);

`ifdef UART_RX_PARITY_EN
      snap();
      send_frame_raw(8'h07, 1'b0, 1'b1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("par_bad_pe", pe_cnt - peb, 1);
      check("par_bad_acc", got_q.size() - qb, 1);
      if (got_q.size() > qb) check("par_bad_byte", int'(got_q[qb]), 8'h07);
      snap();
      send_frame_raw(8'h07, 1'b1, 1'b1);
      rx = 1'b1;
      wait_ticks(2 * OVS);
      check("par_ok_pe", pe_cnt - peb, 0);
      check("par_ok_acc", got_q.size() - qb, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter OVERSAMPLE, default 16, is the number of sample_tick pulses per bit; it SHALL be an even value of at least 4.
- REQ-002: Port clock, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
- REQ-003: Port reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004: Port sample_tick, input, 1 bit: one-clock enable pulse at OVERSAMPLE times the baud rate.
- REQ-005: Port rx, input, 1 bit: asynchronous serial line, idle high.
- REQ-006: Port byte_received, output, 8 bits: the received data byte.
- REQ-007: Port valid, output, 1 bit: byte_received holds an unconsumed byte.
- REQ-008: Port ready, input, 1 bit: the consumer accepts the byte when valid and ready are both high.
- REQ-009: Port framing_error, output, 1 bit: one-clock pulse when the stop bit is sampled low.
- REQ-010: Port overrun, output, 1 bit: one-clock pulse when a byte completes while the holding register is still full.

Function
- REQ-011: rx SHALL pass through a 2-flop synchronizer before use; all decisions use the synchronized value rx_s (2-clock input latency).
- REQ-012: The FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; the FSM and the tick counter SHALL advance only on sample_tick.
- REQ-013: IDLE: rx_s = 0 on a tick goes to START with tick_cnt = 0.
- REQ-014: START: at tick_cnt = OVERSAMPLE/2-1 (mid-bit), rx_s = 1 counts as a glitch and returns to IDLE; rx_s = 0 goes to DATA with tick_cnt reset and bit_idx = 0.
- REQ-015: DATA: sample every OVERSAMPLE ticks at mid-bit and shift in LSB first; after bit_idx = 7, go to STOP.
- REQ-016: STOP, mid-bit, rx_s = 1: load the shift register into byte_received and go to IDLE.
- REQ-017: STOP, mid-bit, rx_s = 0: pulse framing_error, discard the byte, and go to WAIT_HIGH.
- REQ-018: WAIT_HIGH (break or line low): stay until rx_s = 1 on a tick, then go to IDLE.
- REQ-019: Handshake: valid rises the clock after the load; byte_received SHALL be stable while valid = 1.
- REQ-020: valid SHALL clear on the clock where valid && ready.
- REQ-021: Load while valid = 1 and ready = 0: keep the old byte, drop the new byte, and pulse overrun.
- REQ-022: Load on the same clock as a consume: take the new byte, keep valid = 1, and do not pulse overrun.
- REQ-023: ready SHALL be ignored while valid = 0.
- REQ-024: Back-to-back frames (stop bit followed immediately by a start bit) SHALL be received without loss; IDLE re-arms on the next tick.

Reset
- REQ-025: When reset_n is low, asynchronously: state = IDLE; counters = 0; byte_received = 8'h00; valid, framing_error and overrun = 0; synchronizer flops = 1.
- REQ-026: Deasserting reset mid-frame SHALL NOT produce a partial byte; reception resumes at the next falling edge seen in IDLE.

Configuration
- REQ-027: Macro UART_RX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP; even parity is checked at mid-bit; output parity_error (1 bit) pulses on mismatch; the byte is still delivered.
- REQ-028: Macro UART_RX_PARITY_EN undefined: there is no PARITY state and no parity_error port; the frame is 8N1.

Structure
- REQ-029: Package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE_DEFAULT = 16, and DATA_BITS = 8, shared with uart_tx.
- REQ-030: Sub-module sync_2ff SHALL implement the rx synchronizer with reset value 1; it is reusable elsewhere.
- REQ-031: The tick generator stays external; the baud_tick block provides sample_tick.

Verification
- REQ-032: An 8N1 frame 0x58 with ready = 1 SHALL give valid for one clock with byte_received = 0x58; framing_error = 0 and overrun = 0.
- REQ-033: Frames 0xAC then 0x58 back-to-back with ready = 0, then ready = 1, SHALL keep byte = 0xAC, pulse overrun once, and deliver 0xAC only.
- REQ-034: A rx low pulse of OVERSAMPLE/4 ticks from idle SHALL give no valid; the FSM returns to IDLE.
- REQ-035: Frame 0x55 with stop bit 0 and rx held low for 30 bit times SHALL pulse framing_error once and give no valid; a following 0x0F frame SHALL be received correctly.
- REQ-036: reset_n asserted at DATA bit 4 of 0xFF, then a clean 0x3C frame, SHALL give byte_received = 0x3C only.
- REQ-037: With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 SHALL deliver 0x07 with parity_error pulsed; with parity bit 1 there SHALL be no error.
